io_break_arbiter: RTL and testbench

- Parametrised data-break (DMA) arbiter and interrupt aggregator for the PDP-8/E core.
- Generalises the single-device break path (one disk, fixed break_in_prog/data_break wiring) and the fixed three-source irq OR to NCH break channels and NIRQ interrupt sources.
- Sits between the peripheral controllers (RK8E, future DECtape/LPT) and the ma/state_machine break interface.
- Provides round-robin fairness, a memory-cycle timeout, and a registered prioritised interrupt request.

---
 rtl/io_break_arbiter.sv | 140 ++++++++++++++
 tb/tb_io_break_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_break_arbiter.sv
// Data-break (DMA) arbiter for NCH peripheral channels with round-robin grant and
// memory-cycle timeout, plus a registered prioritised interrupt aggregator.
module io_break_arbiter #(
  parameter int NCH  = 2,
  parameter int NIRQ = 4,
  parameter int AW   = 15,
  parameter int DW   = 12,
  parameter int TMO  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [NCH-1:0]    brk_req,
  input  logic [NCH*AW-1:0] brk_addr,
  input  logic [NCH-1:0]    brk_to_mem,
  input  logic [NCH*DW-1:0] brk_wdata,
  output logic [NCH-1:0]    brk_done,
  output logic [NCH-1:0]    brk_err,
  output logic [DW-1:0]     brk_rdata,
  input  logic              cpu_break_ok,
  input  logic              mem_ack,
  input  logic [DW-1:0]     dmaDIN,
  output logic [AW-1:0]     dmaAddr,
  output logic [DW-1:0]     dmaDOUT,
  output logic              to_mem,
  output logic              data_break,
  output logic              break_in_prog,
  input  logic [NIRQ-1:0]   irq_src,
  input  logic [NIRQ-1:0]   irq_mask,
  output logic              irq,
  output logic [3:0]        irq_id
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TMO);

  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

  state_t          state;
  logic [CW-1:0]   ch;
  logic [CW-1:0]   last;
  logic [TW-1:0]   cnt;
  logic [CW-1:0]   pick;
  logic [NIRQ-1:0] irq_act;
  logic [3:0]      irq_enc;

  // First requester strictly above the last-served channel, else wrap to the lowest one.
  function automatic logic [CW-1:0] rr_pick(input logic [NCH-1:0] req,
                                            input logic [CW-1:0]  last_ch);
    logic [CW-1:0] lo;
    logic [CW-1:0] hi;
    logic          hi_ok;
    lo    = '0;
    hi    = '0;
    hi_ok = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo = CW'(i);
        if (i > int'(last_ch)) begin
          hi    = CW'(i);
          hi_ok = 1'b1;
        end
      end
    end
    return hi_ok ? hi : lo;
  endfunction

  always_comb begin
    pick    = rr_pick(brk_req, last);
    irq_act = irq_src & irq_mask;
    irq_enc = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq_act[i]) irq_enc = 4'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ch            <= '0;
      last          <= CW'(NCH - 1);
      cnt           <= '0;
      brk_done      <= '0;
      brk_err       <= '0;
      brk_rdata     <= '0;
      dmaAddr       <= '0;
      dmaDOUT       <= '0;
      to_mem        <= 1'b0;
      data_break    <= 1'b0;
      break_in_prog <= 1'b0;
      irq           <= 1'b0;
      irq_id        <= '0;
    end else begin
      brk_done <= '0;
      brk_err  <= '0;
      irq      <= |irq_act;
      irq_id   <= irq_enc;
      case (state)
        IDLE: begin
          if (clear) begin
            last <= CW'(NCH - 1);
          end else if (cpu_break_ok && |brk_req) begin
            ch            <= pick;
            dmaAddr       <= brk_addr[int'(pick)*AW +: AW];
            dmaDOUT       <= brk_wdata[int'(pick)*DW +: DW];
            to_mem        <= brk_to_mem[pick];
            cnt           <= '0;
            data_break    <= 1'b1;
            break_in_prog <= 1'b1;
            state         <= XFER;
          end
        end
        XFER: begin
          // clear is deliberately ignored here: the memory cycle must complete.
          if (mem_ack || cnt == TW'(TMO - 1)) begin
            if (mem_ack) begin
              if (!to_mem) brk_rdata <= dmaDIN;
              brk_done[ch] <= 1'b1;
            end else begin
              brk_err[ch] <= 1'b1;
            end
            data_break    <= 1'b0;
            break_in_prog <= 1'b0;
            last          <= ch;
            state         <= RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          cnt   <= '0;
          if (clear) last <= CW'(NCH - 1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_break_arbiter.sv
// Directed bench for io_break_arbiter: interrupt vector table plus hand-written
// break-cycle sequences (read, round-robin, timeout, gating, clear, reset).
module tb_io_break_arbiter;

  localparam int NCH  = 2;
  localparam int NIRQ = 4;
  localparam int AW   = 15;
  localparam int DW   = 12;
  localparam int TMO  = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear;
  logic [NCH-1:0]    brk_req;
  logic [NCH*AW-1:0] brk_addr;
  logic [NCH-1:0]    brk_to_mem;
  logic [NCH*DW-1:0] brk_wdata;
  logic [NCH-1:0]    brk_done;
  logic [NCH-1:0]    brk_err;
  logic [DW-1:0]     brk_rdata;
  logic              cpu_break_ok;
  logic              mem_ack;
  logic [DW-1:0]     dmaDIN;
  logic [AW-1:0]     dmaAddr;
  logic [DW-1:0]     dmaDOUT;
  logic              to_mem;
  logic              data_break;
  logic              break_in_prog;
  logic [NIRQ-1:0]   irq_src;
  logic [NIRQ-1:0]   irq_mask;
  logic              irq;
  logic [3:0]        irq_id;

  always #5 clk = ~clk;

  io_break_arbiter #(.NCH(NCH), .NIRQ(NIRQ), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .brk_req(brk_req), .brk_addr(brk_addr), .brk_to_mem(brk_to_mem),
    .brk_wdata(brk_wdata), .brk_done(brk_done), .brk_err(brk_err),
    .brk_rdata(brk_rdata), .cpu_break_ok(cpu_break_ok), .mem_ack(mem_ack),
    .dmaDIN(dmaDIN), .dmaAddr(dmaAddr), .dmaDOUT(dmaDOUT), .to_mem(to_mem),
    .data_break(data_break), .break_in_prog(break_in_prog),
    .irq_src(irq_src), .irq_mask(irq_mask), .irq(irq), .irq_id(irq_id)
  );

  typedef struct {
    logic [3:0] src;
    logic [3:0] mask;
    logic       exp_irq;
    logic [3:0] exp_id;
  } irq_vec_t;

  irq_vec_t vt[7];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int db_cnt;
    int order[6];
    int when[6];
    int errk;
    int bad;
    logic done_seen;

    vt[0] = '{4'b1010, 4'b1111, 1'b1, 4'd1};
    vt[1] = '{4'b1010, 4'b0111, 1'b1, 4'd1};
    vt[2] = '{4'b1010, 4'b0101, 1'b0, 4'd0};
    vt[3] = '{4'b0000, 4'b1111, 1'b0, 4'd0};
    vt[4] = '{4'b1000, 4'b1111, 1'b1, 4'd3};
    vt[5] = '{4'b1111, 4'b1110, 1'b1, 4'd1};
    vt[6] = '{4'b0001, 4'b0001, 1'b1, 4'd0};

    reset        = 1'b1;
    clear        = 1'b0;
    brk_req      = '0;
    brk_addr     = {15'o05555, 15'o01234};
    brk_to_mem   = '0;
    brk_wdata    = {12'o4321, 12'o1357};
    cpu_break_ok = 1'b0;
    mem_ack      = 1'b0;
    dmaDIN       = '0;
    irq_src      = '0;
    irq_mask     = '0;
    tick();
    tick();

    chk("reset_data_break", 32'(data_break), 32'd0);
    chk("reset_bip", 32'(break_in_prog), 32'd0);
    chk("reset_done_err", 32'({brk_done, brk_err}), 32'd0);
    chk("reset_dma", 32'({dmaAddr, to_mem}), 32'd0);
    chk("reset_dout_rdata", 32'({dmaDOUT, brk_rdata}), 32'd0);
    chk("reset_irq", 32'({irq, irq_id}), 32'd0);
    reset = 1'b0;
    tick();

    // Interrupt vectors
    for (int i = 0; i < 7; i++) begin
      irq_src  = vt[i].src;
      irq_mask = vt[i].mask;
      tick();
      chk($sformatf("irq_vec%0d", i), 32'(irq), 32'(vt[i].exp_irq));
      chk($sformatf("irq_id_vec%0d", i), 32'(irq_id), 32'(vt[i].exp_id));
    end
    irq_src = '0;
    #1;
    chk("irq_latency_hold", 32'(irq), 32'd1);
    tick();
    chk("irq_latency_drop", 32'(irq), 32'd0);
    irq_mask = '0;

    // Single read on ch0 with latched-address stability
    brk_req      = 2'b01;
    cpu_break_ok = 1'b1;
    tick();
    chk("rd_data_break", 32'(data_break), 32'd1);
    chk("rd_bip", 32'(break_in_prog), 32'd1);
    chk("rd_addr", 32'(dmaAddr), 32'o01234);
    chk("rd_to_mem", 32'(to_mem), 32'd0);
    brk_addr[14:0] = 15'o07777;
    tick();
    chk("rd_bip2", 32'(break_in_prog), 32'd1);
    chk("rd_addr_stable", 32'(dmaAddr), 32'o01234);
    tick();
    chk("rd_bip3", 32'(break_in_prog), 32'd1);
    chk("rd_no_early_done", 32'(brk_done), 32'd0);
    mem_ack = 1'b1;
    dmaDIN  = 12'o7070;
    tick();
    chk("rd_done", 32'(brk_done), 32'b01);
    chk("rd_rdata", 32'(brk_rdata), 32'o7070);
    chk("rd_bip_off", 32'({data_break, break_in_prog}), 32'd0);
    mem_ack        = 1'b0;
    brk_req        = '0;
    brk_addr[14:0] = 15'o01234;
    dmaDIN         = '0;
    tick();
    chk("rd_done_pulse", 32'(brk_done), 32'd0);
    chk("rd_rdata_held", 32'(brk_rdata), 32'o7070);

    // clear in IDLE, then round-robin with zero-wait mem_ack
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    brk_req = 2'b11;
    mem_ack = 1'b1;
    nd      = 0;
    db_cnt  = 0;
    for (int s = 0; s < 30 && nd < 6; s++) begin
      tick();
      if (data_break) db_cnt++;
      if (brk_done != '0) begin
        order[nd] = brk_done[1] ? 1 : 0;
        when[nd]  = s;
        nd++;
      end
    end
    brk_req = '0;
    mem_ack = 1'b0;
    tick();
    chk("rr_count", 32'(nd), 32'd6);
    chk("rr_db_cycles", 32'(db_cnt), 32'd6);
    chk("rr_first_latency", 32'(when[0]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % 2));
    end
    bad = 0;
    for (int k = 1; k < 6; k++) begin
      if (when[k] - when[k-1] != 3) bad++;
    end
    chk("rr_spacing", 32'(bad), 32'd0);

    // Timeout on ch1 write
    brk_req    = 2'b10;
    brk_to_mem = 2'b10;
    tick();
    chk("to_addr", 32'(dmaAddr), 32'o05555);
    chk("to_dout", 32'(dmaDOUT), 32'o4321);
    chk("to_dir", 32'(to_mem), 32'd1);
    errk      = -1;
    done_seen = 1'b0;
    bad       = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (brk_done != '0) done_seen = 1'b1;
      if (brk_err != '0 && errk < 0) begin
        errk    = k;
        if (brk_err != 2'b10) bad++;
        brk_req = '0;
      end
    end
    chk("to_err_cycle", 32'(errk), 32'd8);
    chk("to_err_channel", 32'(bad), 32'd0);
    chk("to_no_done", 32'(done_seen), 32'd0);
    chk("to_idle", 32'({data_break, break_in_prog}), 32'd0);
    brk_to_mem = '0;

    // mem_ack on the timeout cycle wins over the timeout
    brk_req = 2'b01;
    tick();
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      if (brk_err != '0 || brk_done != '0) bad++;
    end
    chk("tie_quiet", 32'(bad), 32'd0);
    mem_ack = 1'b1;
    dmaDIN  = 12'o0707;
    tick();
    chk("tie_done", 32'(brk_done), 32'b01);
    chk("tie_no_err", 32'(brk_err), 32'd0);
    chk("tie_rdata", 32'(brk_rdata), 32'o0707);
    mem_ack = 1'b0;
    brk_req = '0;
    tick();

    // Gating by cpu_break_ok
    brk_req      = 2'b01;
    cpu_break_ok = 1'b0;
    bad          = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (data_break || break_in_prog) bad++;
    end
    chk("gate_no_break", 32'(bad), 32'd0);

    // clear during XFER is ignored
    cpu_break_ok = 1'b1;
    tick();
    chk("clrx_grant", 32'(data_break), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrx_still_xfer", 32'(data_break), 32'd1);
    mem_ack = 1'b1;
    tick();
    chk("clrx_done", 32'(brk_done), 32'b01);
    mem_ack = 1'b0;
    brk_req = '0;
    tick();

    // clear in IDLE restarts the round-robin at ch0 (last served was ch0)
    clear = 1'b1;
    tick();
    clear   = 1'b0;
    brk_req = 2'b11;
    tick();
    chk("clri_grant_ch0", 32'(dmaAddr), 32'o01234);
    mem_ack = 1'b1;
    tick();
    chk("clri_done", 32'(brk_done), 32'b01);
    mem_ack = 1'b0;
    brk_req = '0;
    tick();

    // Asynchronous reset mid-XFER
    irq_src  = 4'b1111;
    irq_mask = 4'b1111;
    brk_req  = 2'b10;
    tick();
    chk("rst_pre_addr", 32'(dmaAddr), 32'o05555);
    chk("rst_pre_irq", 32'(irq), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_break", 32'({data_break, break_in_prog}), 32'd0);
    chk("rst_async_addr", 32'(dmaAddr), 32'd0);
    chk("rst_async_irq", 32'(irq), 32'd0);
    mem_ack = 1'b1;
    tick();
    chk("rst_no_done", 32'({brk_done, brk_err}), 32'd0);
    reset    = 1'b0;
    mem_ack  = 1'b0;
    irq_src  = '0;
    brk_req  = 2'b11;
    tick();
    chk("rst_first_grant_ch0", 32'(dmaAddr), 32'o01234);
    mem_ack = 1'b1;
    tick();
    chk("rst_done_ch0", 32'(brk_done), 32'b01);
    mem_ack = 1'b0;
    brk_req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
